// File: rtl/mtc_sl_link_scheduler.sv
// ---------------------------------------------------------------------------
// mtc_sl_link_scheduler
//
// Purpose:
//   Collects up to N_IN candidate MTC2SL words per clock from the MTC builder.
//   The valid lanes are packed, lowest lane first, into a shared circular
//   buffer. The buffer is drained one word per cycle towards the sector-logic
//   link serializer through a show-ahead valid/ready interface. Candidates
//   that do not fit are dropped and counted.
//
// Ports:
//   clock        system clock
//   rst          synchronous active-high reset
//   srst         synchronous active-high soft reset (same effect as rst)
//   mtc_i        N_IN candidate words; the MSB of each word is its valid flag
//   mtc_o        registered head word, all zero while mtc_o_valid = 0
//   mtc_o_valid  head word present
//   mtc_o_ready  link takes the head word this cycle
//   occupancy    number of stored entries, head included
//   drop_cnt     saturating count of candidates lost on overflow
//   overflow     one-cycle pulse in the cycle after any drop
// ---------------------------------------------------------------------------
module mtc_sl_link_scheduler #(
    parameter int DATA_WIDTH = 32,   // MTC2SL word length
    parameter int N_IN       = 3,
    parameter int FIFO_DEPTH = 16,   // power of 2, >= N_IN
    parameter int CNT_WIDTH  = 16
) (
    input  logic                          clock,
    input  logic                          rst,
    input  logic                          srst,
    input  logic [DATA_WIDTH-1:0]         mtc_i [N_IN],
    output logic [DATA_WIDTH-1:0]         mtc_o,
    output logic                          mtc_o_valid,
    input  logic                          mtc_o_ready,
    output logic [$clog2(FIFO_DEPTH):0]   occupancy,
    output logic [CNT_WIDTH-1:0]          drop_cnt,
    output logic                          overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int OW = AW + 1;
    localparam int SW = CNT_WIDTH + 1;

    // Saturating accumulate for the drop counter.
    function automatic logic [CNT_WIDTH-1:0] sat_add(
        input logic [CNT_WIDTH-1:0] acc,
        input logic [OW-1:0]        inc
    );
        logic [SW-1:0] sum;
        sum = {1'b0, acc} + SW'(inc);
        if (sum[CNT_WIDTH])
            return '1;
        else
            return sum[CNT_WIDTH-1:0];
    endfunction

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

    logic [AW-1:0]         rd_ptr;
    logic [AW-1:0]         wr_ptr;

    logic [OW-1:0]         n_v;
    logic [OW-1:0]         free_slots;
    logic [OW-1:0]         n_acc;
    logic [OW-1:0]         n_drop;
    logic [OW-1:0]         occ_next;
    logic [OW-1:0]         rank    [N_IN];
    logic                  wr_en   [N_IN];
    logic [AW-1:0]         wr_addr [N_IN];
    logic                  pop;
    logic                  reset_any;
    logic [AW-1:0]         rd_ptr_next;
    logic [AW-1:0]         wr_ptr_next;
    logic [DATA_WIDTH-1:0] head_next;

    assign reset_any = rst | srst;

    // Input compaction, admission and next-head selection
    always_comb begin
        n_v = '0;
        for (int k = 0; k < N_IN; k++) begin
            // rank = number of valid lanes below lane k = its slot offset
            rank[k] = n_v;
            n_v     = n_v + OW'(mtc_i[k][DATA_WIDTH-1]);
        end

        // Free space is taken from the start-of-cycle occupancy; a pop in
        // the same cycle does not make room for this cycle's inputs.
        free_slots = OW'(FIFO_DEPTH) - occupancy;
        n_acc      = (n_v < free_slots) ? n_v : free_slots;
        n_drop     = n_v - n_acc;

        for (int k = 0; k < N_IN; k++) begin
            wr_en[k]   = mtc_i[k][DATA_WIDTH-1] && (rank[k] < n_acc);
            wr_addr[k] = wr_ptr + rank[k][AW-1:0];
        end

        pop         = mtc_o_valid & mtc_o_ready;
        occ_next    = occupancy + n_acc - OW'(pop);
        rd_ptr_next = rd_ptr + AW'(pop);
        // n_acc never exceeds FIFO_DEPTH, so its low bits wrap correctly
        wr_ptr_next = wr_ptr + n_acc[AW-1:0];

        // The new head is either already stored or is being written in this
        // very cycle (buffer drained down to nothing before the writes land).
        // A write can only hit rd_ptr_next when that slot is free, so the
        // bypass never shadows a live entry.
        head_next = mem[rd_ptr_next];
        for (int k = 0; k < N_IN; k++) begin
            if (wr_en[k] && (wr_addr[k] == rd_ptr_next))
                head_next = mtc_i[k];
        end
    end

    // Buffer storage (no reset: contents are meaningless while empty)
    always_ff @(posedge clock) begin
        for (int k = 0; k < N_IN; k++) begin
            if (wr_en[k])
                mem[wr_addr[k]] <= mtc_i[k];
        end
    end

    // Pointers, occupancy, drop accounting and show-ahead output register
    always_ff @(posedge clock) begin
        if (reset_any) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            occupancy   <= '0;
            drop_cnt    <= '0;
            overflow    <= 1'b0;
            mtc_o_valid <= 1'b0;
            mtc_o       <= '0;
        end else begin
            rd_ptr      <= rd_ptr_next;
            wr_ptr      <= wr_ptr_next;
            occupancy   <= occ_next;
            drop_cnt    <= sat_add(drop_cnt, n_drop);
            overflow    <= (n_drop != '0);
            mtc_o_valid <= (occ_next != '0);
            mtc_o       <= (occ_next != '0) ? head_next : '0;
        end
    end

endmodule

// File: tb/tb_mtc_sl_link_scheduler.sv
// ---------------------------------------------------------------------------
// tb_mtc_sl_link_scheduler
//
// Purpose:
//   Bench for mtc_sl_link_scheduler. A driver issues directed and random
//   traffic; for every admitted candidate it pushes the expected word into a
//   scoreboard queue. A monitor on the falling edge compares the presented
//   head word and the status outputs against a queue-level reference model.
// ---------------------------------------------------------------------------
module tb_mtc_sl_link_scheduler;

    localparam int DW    = 16;
    localparam int PW    = DW - 1;
    localparam int NL    = 3;
    localparam int DEPTH = 16;
    localparam int CW    = 5;
    localparam int MAXC  = (1 << CW) - 1;

    logic                   clock = 1'b0;
    logic                   rst   = 1'b0;
    logic                   srst  = 1'b0;
    logic [DW-1:0]          mtc_i [NL];
    logic [DW-1:0]          mtc_o;
    logic                   mtc_o_valid;
    logic                   mtc_o_ready = 1'b0;
    logic [$clog2(DEPTH):0] occupancy;
    logic [CW-1:0]          drop_cnt;
    logic                   overflow;

    mtc_sl_link_scheduler #(
        .DATA_WIDTH (DW),
        .N_IN       (NL),
        .FIFO_DEPTH (DEPTH),
        .CNT_WIDTH  (CW)
    ) dut (
        .clock       (clock),
        .rst         (rst),
        .srst        (srst),
        .mtc_i       (mtc_i),
        .mtc_o       (mtc_o),
        .mtc_o_valid (mtc_o_valid),
        .mtc_o_ready (mtc_o_ready),
        .occupancy   (occupancy),
        .drop_cnt    (drop_cnt),
        .overflow    (overflow)
    );

    always #5 clock = ~clock;

    // Reference model state: values expected after the most recent edge.
    logic [DW-1:0] exp_q [$];
    int            cur_occ  = 0;
    int            cur_drop = 0;
    int            cur_ovf  = 0;
    int            nxt_occ, nxt_drop, nxt_ovf;
    bit            started  = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [DW-1:0] vw();
        return {1'b1, PW'($urandom)};
    endfunction

    function automatic logic [DW-1:0] iw();
        return {1'b0, PW'($urandom)};
    endfunction

    function automatic logic [DW-1:0] lane(input bit v);
        return v ? vw() : iw();
    endfunction

    // Apply one cycle of stimulus, advance the model across the coming edge.
    task automatic drive(input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                         input logic [DW-1:0] w2, input logic rdy,
                         input logic rs, input logic ss);
        logic [DW-1:0] w [NL];
        int nv, acc, free_n, popn, d;
        w[0] = w0; w[1] = w1; w[2] = w2;
        for (int k = 0; k < NL; k++) mtc_i[k] = w[k];
        mtc_o_ready = rdy;
        rst         = rs;
        srst        = ss;
        if (rs || ss) begin
            nxt_occ  = 0;
            nxt_drop = 0;
            nxt_ovf  = 0;
            exp_q.delete();
        end else begin
            nv     = 0;
            acc    = 0;
            free_n = DEPTH - cur_occ;
            popn   = (cur_occ > 0 && rdy) ? 1 : 0;
            for (int k = 0; k < NL; k++) begin
                if (w[k][DW-1]) begin
                    nv++;
                    if (acc < free_n) begin
                        exp_q.push_back(w[k]);
                        acc++;
                    end
                end
            end
            d        = nv - acc;
            nxt_occ  = cur_occ + acc - popn;
            nxt_drop = (cur_drop + d > MAXC) ? MAXC : cur_drop + d;
            nxt_ovf  = (d > 0) ? 1 : 0;
        end
        @(posedge clock);
        #1;
        cur_occ  = nxt_occ;
        cur_drop = nxt_drop;
        cur_ovf  = nxt_ovf;
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) drive(iw(), iw(), iw(), rdy, 1'b0, 1'b0);
    endtask

    task automatic rnd(input logic [2:0] m, input logic rdy);
        drive(lane(m[0]), lane(m[1]), lane(m[2]), rdy, 1'b0, 1'b0);
    endtask

    // Monitor: compare presented outputs with the model between edges.
    always @(negedge clock) begin
        if (started && !(rst || srst)) begin
            chk("occupancy", 64'(occupancy), 64'(cur_occ));
            chk("drop_cnt", 64'(drop_cnt), 64'(cur_drop));
            chk("overflow", 64'(overflow), 64'(cur_ovf));
            chk("valid", 64'(mtc_o_valid), 64'(cur_occ > 0));
            if (cur_occ > 0) begin
                if (exp_q.size() == 0) begin
                    chk("scoreboard_empty", 64'(exp_q.size()), 64'(1));
                end else begin
                    chk("head_word", 64'(mtc_o), 64'(exp_q[0]));
                    if (mtc_o_ready) void'(exp_q.pop_front());
                end
            end else begin
                chk("idle_zero", 64'(mtc_o), 64'(0));
            end
        end
    end

    initial begin
        for (int k = 0; k < NL; k++) mtc_i[k] = '0;

        // Reset, then idle
        drive(iw(), iw(), iw(), 1'b0, 1'b1, 1'b0);
        drive(iw(), iw(), iw(), 1'b0, 1'b1, 1'b0);
        started = 1'b1;
        idle(20, 1'b0);

        // Lanes 0 and 2 valid in one cycle, link ready
        drive(16'h800A, iw(), 16'h800C, 1'b1, 1'b0, 1'b0);
        chk("first_word", 64'(mtc_o), 64'h800A);
        idle(1, 1'b1);
        chk("second_word", 64'(mtc_o), 64'h800C);
        idle(1, 1'b1);
        chk("drained_valid", 64'(mtc_o_valid), 64'(0));
        idle(3, 1'b1);

        // Stalled link, three lanes valid for six cycles
        for (int i = 0; i < 6; i++) rnd(3'b111, 1'b0);
        chk("full_occ", 64'(occupancy), 64'(DEPTH));
        idle(4, 1'b0);
        chk("stall_drops", 64'(drop_cnt), 64'(2));

        // Full with a pop and a valid input in the same cycle
        rnd(3'b001, 1'b1);
        chk("full_pop_occ", 64'(occupancy), 64'(DEPTH - 1));
        chk("full_pop_drops", 64'(drop_cnt), 64'(3));
        idle(20, 1'b1);

        // Sustained one lane per cycle, link ready
        for (int i = 0; i < 40; i++) rnd(3'(1 << $urandom_range(0, 2)), 1'b1);
        idle(3, 1'b1);

        // Soft reset with seven entries stored
        rnd(3'b111, 1'b0);
        rnd(3'b111, 1'b0);
        rnd(3'b010, 1'b0);
        chk("pre_srst_occ", 64'(occupancy), 64'(7));
        drive(iw(), iw(), iw(), 1'b0, 1'b0, 1'b1);
        chk("srst_occ", 64'(occupancy), 64'(0));
        chk("srst_drop", 64'(drop_cnt), 64'(0));
        rnd(3'b100, 1'b1);
        chk("post_srst_valid", 64'(mtc_o_valid), 64'(1));
        idle(3, 1'b1);

        // Random traffic with varying link back-pressure
        for (int seg = 0; seg < 6; seg++) begin
            for (int i = 0; i < 500; i++) begin
                logic rdy;
                rdy = (seg % 2 == 0) ? ($urandom_range(0, 3) == 0)
                                     : ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 699) == 0)
                    drive(iw(), iw(), iw(), rdy, $urandom_range(0, 1) == 1,
                          1'b1);
                else
                    rnd(3'($urandom_range(0, 7)), rdy);
            end
        end

        idle(30, 1'b1);
        chk("final_drain", 64'(exp_q.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mtc_sl_link_scheduler.md
Name: mtc_sl_link_scheduler

Overview:
- Sits directly downstream of the MTC builder in the MTC block.
- Each clock it accepts up to N_IN candidate MTC2SL words, one per primary MTC lane; bit MTC2SL_LEN-1 of each word is its valid flag.
- It compacts the valid lanes into a shared circular buffer in ascending lane order.
- It drains the buffer one word per cycle to the sector-logic link serializer through a valid/ready handshake, and counts candidates lost on overflow.

Parameters:
- DATA_WIDTH, default MTC2SL_LEN: candidate word width; MSB is the valid flag.
- N_IN, default 3: input lanes per clock (n_PRIMARY_MTC).
- FIFO_DEPTH, default 16: buffer entries; must be a power of 2, and at least N_IN.
- CNT_WIDTH, default 16: drop counter width.

Ports:
- clock  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- srst  in  1  synchronous active-high soft reset; identical effect to rst.
- mtc_i  in  DATA_WIDTH x N_IN  candidate words from the MTC builder; lane k is valid when mtc_i[k][DATA_WIDTH-1] = 1.
- mtc_o  out  DATA_WIDTH  head word to the link; all zero when mtc_o_valid = 0.
- mtc_o_valid  out  1  head word present.
- mtc_o_ready  in  1  link accepts the head word this cycle.
- occupancy  out  clog2(FIFO_DEPTH)+1  entries currently stored, including the head.
- drop_cnt  out  CNT_WIDTH  candidates discarded on overflow; saturates at all-ones.
- overflow  out  1  one-cycle pulse, asserted the cycle after any drop.

Behaviour:
- Reset: when rst or srst = 1 at a clock edge:
  - read pointer, write pointer, occupancy and drop_cnt are set to 0;
  - mtc_o is set to 0, mtc_o_valid to 0, overflow to 0;
  - buffer contents are don't-care.
  - A reset mid-stream discards everything buffered. There is no partial drain.
- Input compaction:
  - n_v = number of lanes with the valid flag set.
  - Valid lanes are written to consecutive addresses starting at wr_ptr, lowest lane index first; invalid lanes leave no gaps.
  - The whole word, valid bit included, is stored unchanged.
- Free space: free = FIFO_DEPTH - occupancy, sampled at the start of the cycle. A pop in the same cycle is NOT credited.
- Accepted writes: n_acc = min(n_v, free). The first n_acc valid lanes in index order are written; the remaining n_v - n_acc are dropped.
- Drop accounting:
  - drop_cnt += (n_v - n_acc), saturating at 2^CNT_WIDTH-1.
  - overflow = 1 on the next cycle whenever n_v - n_acc > 0.
- Pop: occurs when mtc_o_valid & mtc_o_ready.
  - rd_ptr advances by 1.
  - occupancy_next = occupancy + n_acc - pop.
  - Simultaneous push and pop are legal at any occupancy.
- Output register: mtc_o and mtc_o_valid are registered (show-ahead).
  - After any cycle leaving occupancy_next > 0, mtc_o holds the entry at the new rd_ptr and mtc_o_valid = 1.
  - Otherwise mtc_o = 0 and mtc_o_valid = 0.
- Latency: a word written to an empty buffer at edge t appears on mtc_o with mtc_o_valid = 1 immediately after edge t (one cycle input to output).
- Throughput: at most 1 word out per cycle.
- Stalled output: while mtc_o_ready = 0, mtc_o and mtc_o_valid hold stable.
- Ordering:
  - Strict FIFO across cycles.
  - Within a cycle, lane 0 precedes lane 1 precedes lane 2.
- Pointers: both are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. Full/empty is determined from occupancy, not from pointer equality.
- Full: occupancy = FIFO_DEPTH. All valid inputs that cycle are dropped, even if a pop also occurs.
- Empty: occupancy = 0 and mtc_o_valid = 0. mtc_o_ready is ignored.

Test Plan:
- Reset, then idle with all lanes invalid -> mtc_o_valid = 0, mtc_o = 0, occupancy = 0, drop_cnt = 0 for 20 cycles.
- One cycle with lanes 0 and 2 valid (payloads 0xA, 0xC, valid bit set) and mtc_o_ready = 1:
  - cycle t+1: mtc_o = lane0 word;
  - cycle t+2: mtc_o = lane2 word;
  - cycle t+3: mtc_o_valid = 0.
- mtc_o_ready = 0, all 3 lanes valid each cycle for 6 cycles, FIFO_DEPTH = 16:
  - occupancy steps 3, 6, 9, 12, 15, 16;
  - cycle 6 accepts 1 word and drops 2; cycle 6 stalls with occupancy = 16.
  - Then drop_cnt = 2, overflow pulses exactly one cycle, and mtc_o still shows the very first word.
- Buffer full, mtc_o_ready = 1, 1 lane valid in the same cycle -> input dropped (drop_cnt +1), pop occurs, occupancy = 15.
- Sustained 1 valid lane per cycle with mtc_o_ready = 1 for 40 cycles -> output sequence equals input sequence, occupancy stays ≤ 1, pointers wrap twice, and no drops occur.
- srst asserted mid-stream with occupancy = 7 -> next cycle occupancy = 0, mtc_o_valid = 0, drop_cnt = 0. New input after release emerges 1 cycle later.
